axil_merge: RTL and testbench

- N:1 AXI-lite merge: arbitrates NUM_SRCS AXI-lite initiators onto one AXI-lite destination, e.g. instruction fetch and data port sharing one RAM.
- Mirror of the data-side split.
- Write and read paths are independent. Each has a round-robin arbiter and a routing FIFO that records the granted source index, so responses return to the right initiator in order.
- Zero-latency combinational pass-through once granted.

---
 rtl/axil_merge.sv | 263 ++++++++++++++++++++++++++
 tb/tb_axil_merge.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axil_merge.sv
// N:1 AXI-lite merge: per-direction arbiter plus routing FIFO that steers responses back in order.
// Optional: define AXIL_MERGE_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.

module axil_merge_arb #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             full,
    input  logic             hs,
    output logic             active,
    output logic [IDX_W-1:0] gnt
);
    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] gnt_q;
    logic [IDX_W-1:0] pick;

`ifdef AXIL_MERGE_FIXED_PRIO_EN
    always_comb begin
        pick = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) pick = IDX_W'(i);
    end
`else
    logic [IDX_W-1:0] ptr_q;

    // Scan far-to-near so the requester closest after the pointer is assigned last and wins.
    always_comb begin
        int idx;
        pick = ptr_q;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr_q) + k) % N;
            if (req[idx]) pick = IDX_W'(idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     ptr_q <= IDX_W'(N - 1);
        else if (hs) ptr_q <= gnt;
    end
`endif

    always_comb begin
        state_d = state_q;
        active  = 1'b0;
        gnt     = gnt_q;
        if (!rst) begin
            case (state_q)
                ARB_IDLE: begin
                    if (!full && (|req)) begin
                        active = 1'b1;
                        gnt    = pick;
                        if (!hs) state_d = ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    active = 1'b1;
                    if (hs) state_d = ARB_IDLE;
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ARB_IDLE && active && !hs) gnt_q <= pick;
        end
    end
endmodule

module axil_merge_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          push_ok, pop_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign dout    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module axil_merge #(
    parameter int NUM_SRCS    = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int OUTSTANDING = 2,
    localparam int IDX_W      = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_SRCS-1:0][ADDR_WIDTH-1:0]  src_axi_awaddr,
    input  logic [NUM_SRCS-1:0]                  src_axi_awvalid,
    output logic [NUM_SRCS-1:0]                  src_axi_awready,
    input  logic [NUM_SRCS-1:0][DATA_WIDTH-1:0]  src_axi_wdata,
    input  logic [NUM_SRCS-1:0][STRB_WIDTH-1:0]  src_axi_wstrb,
    input  logic [NUM_SRCS-1:0]                  src_axi_wvalid,
    output logic [NUM_SRCS-1:0]                  src_axi_wready,
    output logic [NUM_SRCS-1:0][1:0]             src_axi_bresp,
    output logic [NUM_SRCS-1:0]                  src_axi_bvalid,
    input  logic [NUM_SRCS-1:0]                  src_axi_bready,
    input  logic [NUM_SRCS-1:0][ADDR_WIDTH-1:0]  src_axi_araddr,
    input  logic [NUM_SRCS-1:0]                  src_axi_arvalid,
    output logic [NUM_SRCS-1:0]                  src_axi_arready,
    output logic [NUM_SRCS-1:0][DATA_WIDTH-1:0]  src_axi_rdata,
    output logic [NUM_SRCS-1:0][1:0]             src_axi_rresp,
    output logic [NUM_SRCS-1:0]                  src_axi_rvalid,
    input  logic [NUM_SRCS-1:0]                  src_axi_rready,
    output logic [ADDR_WIDTH-1:0]                dst_axi_awaddr,
    output logic                                 dst_axi_awvalid,
    input  logic                                 dst_axi_awready,
    output logic [DATA_WIDTH-1:0]                dst_axi_wdata,
    output logic [STRB_WIDTH-1:0]                dst_axi_wstrb,
    output logic                                 dst_axi_wvalid,
    input  logic                                 dst_axi_wready,
    input  logic [1:0]                           dst_axi_bresp,
    input  logic                                 dst_axi_bvalid,
    output logic                                 dst_axi_bready,
    output logic [ADDR_WIDTH-1:0]                dst_axi_araddr,
    output logic                                 dst_axi_arvalid,
    input  logic                                 dst_axi_arready,
    input  logic [DATA_WIDTH-1:0]                dst_axi_rdata,
    input  logic [1:0]                           dst_axi_rresp,
    input  logic                                 dst_axi_rvalid,
    output logic                                 dst_axi_rready
);
    logic             aw_active, ar_active;
    logic [IDX_W-1:0] aw_gnt, ar_gnt;
    logic             hs_w, hs_r;
    logic             b_empty, b_full, r_empty, r_full;
    logic [IDX_W-1:0] b_head, r_head;
    logic             pop_b, pop_r;

    axil_merge_arb #(.N(NUM_SRCS), .IDX_W(IDX_W)) u_arb_w (
        .clk(clk), .rst(rst), .req(src_axi_awvalid & src_axi_wvalid),
        .full(b_full), .hs(hs_w), .active(aw_active), .gnt(aw_gnt)
    );

    axil_merge_arb #(.N(NUM_SRCS), .IDX_W(IDX_W)) u_arb_r (
        .clk(clk), .rst(rst), .req(src_axi_arvalid),
        .full(r_full), .hs(hs_r), .active(ar_active), .gnt(ar_gnt)
    );

    axil_merge_fifo #(.DEPTH(OUTSTANDING), .W(IDX_W)) u_fifo_b (
        .clk(clk), .rst(rst), .push(hs_w), .din(aw_gnt), .pop(pop_b),
        .dout(b_head), .empty(b_empty), .full(b_full)
    );

    axil_merge_fifo #(.DEPTH(OUTSTANDING), .W(IDX_W)) u_fifo_r (
        .clk(clk), .rst(rst), .push(hs_r), .din(ar_gnt), .pop(pop_r),
        .dout(r_head), .empty(r_empty), .full(r_full)
    );

    // Request side: granted source drives dst; AW and W only ever complete together.
    always_comb begin
        dst_axi_awaddr  = '0;
        dst_axi_awvalid = 1'b0;
        dst_axi_wdata   = '0;
        dst_axi_wstrb   = '0;
        dst_axi_wvalid  = 1'b0;
        src_axi_awready = '0;
        src_axi_wready  = '0;
        if (aw_active) begin
            dst_axi_awaddr  = src_axi_awaddr[aw_gnt];
            dst_axi_awvalid = src_axi_awvalid[aw_gnt];
            dst_axi_wdata   = src_axi_wdata[aw_gnt];
            dst_axi_wstrb   = src_axi_wstrb[aw_gnt];
            dst_axi_wvalid  = src_axi_wvalid[aw_gnt];
            // Source sees readiness only when both channels are accepted in the same cycle.
            src_axi_awready[aw_gnt] = dst_axi_awready & dst_axi_wready;
            src_axi_wready[aw_gnt]  = dst_axi_awready & dst_axi_wready;
        end
    end

    assign hs_w = dst_axi_awvalid & dst_axi_awready & dst_axi_wvalid & dst_axi_wready;

    always_comb begin
        dst_axi_araddr  = '0;
        dst_axi_arvalid = 1'b0;
        src_axi_arready = '0;
        if (ar_active) begin
            dst_axi_araddr          = src_axi_araddr[ar_gnt];
            dst_axi_arvalid         = src_axi_arvalid[ar_gnt];
            src_axi_arready[ar_gnt] = dst_axi_arready;
        end
    end

    assign hs_r = dst_axi_arvalid & dst_axi_arready;

    // Response side: FIFO head selects which source sees the dst response.
    always_comb begin
        src_axi_bvalid = '0;
        src_axi_bresp  = '0;
        dst_axi_bready = 1'b0;
        if (!b_empty) begin
            src_axi_bvalid[b_head] = dst_axi_bvalid;
            src_axi_bresp[b_head]  = dst_axi_bresp;
            dst_axi_bready         = src_axi_bready[b_head];
        end
    end

    always_comb begin
        src_axi_rvalid = '0;
        src_axi_rdata  = '0;
        src_axi_rresp  = '0;
        dst_axi_rready = 1'b0;
        if (!r_empty) begin
            src_axi_rvalid[r_head] = dst_axi_rvalid;
            src_axi_rdata[r_head]  = dst_axi_rdata;
            src_axi_rresp[r_head]  = dst_axi_rresp;
            dst_axi_rready         = src_axi_rready[r_head];
        end
    end

    assign pop_b = dst_axi_bvalid & dst_axi_bready;
    assign pop_r = dst_axi_rvalid & dst_axi_rready;
endmodule

// File: tb/tb_axil_merge.sv
// Directed bench for axil_merge: write path, RR read fairness, lock hold, FIFO full, split valid, async reset.

module tb_axil_merge;
    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0][AW-1:0] src_axi_awaddr, src_axi_araddr;
    logic [N-1:0]         src_axi_awvalid, src_axi_awready, src_axi_wvalid, src_axi_wready;
    logic [N-1:0][DW-1:0] src_axi_wdata, src_axi_rdata;
    logic [N-1:0][SW-1:0] src_axi_wstrb;
    logic [N-1:0][1:0]    src_axi_bresp, src_axi_rresp;
    logic [N-1:0]         src_axi_bvalid, src_axi_bready, src_axi_arvalid, src_axi_arready;
    logic [N-1:0]         src_axi_rvalid, src_axi_rready;
    logic [AW-1:0]        dst_axi_awaddr, dst_axi_araddr;
    logic                 dst_axi_awvalid, dst_axi_awready, dst_axi_wvalid, dst_axi_wready;
    logic [DW-1:0]        dst_axi_wdata, dst_axi_rdata;
    logic [SW-1:0]        dst_axi_wstrb;
    logic [1:0]           dst_axi_bresp, dst_axi_rresp;
    logic                 dst_axi_bvalid, dst_axi_bready, dst_axi_arvalid, dst_axi_arready;
    logic                 dst_axi_rvalid, dst_axi_rready;

    int n_tests = 0;
    int n_fail  = 0;

    axil_merge #(.NUM_SRCS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst),
        .src_axi_awaddr(src_axi_awaddr), .src_axi_awvalid(src_axi_awvalid), .src_axi_awready(src_axi_awready),
        .src_axi_wdata(src_axi_wdata), .src_axi_wstrb(src_axi_wstrb),
        .src_axi_wvalid(src_axi_wvalid), .src_axi_wready(src_axi_wready),
        .src_axi_bresp(src_axi_bresp), .src_axi_bvalid(src_axi_bvalid), .src_axi_bready(src_axi_bready),
        .src_axi_araddr(src_axi_araddr), .src_axi_arvalid(src_axi_arvalid), .src_axi_arready(src_axi_arready),
        .src_axi_rdata(src_axi_rdata), .src_axi_rresp(src_axi_rresp),
        .src_axi_rvalid(src_axi_rvalid), .src_axi_rready(src_axi_rready),
        .dst_axi_awaddr(dst_axi_awaddr), .dst_axi_awvalid(dst_axi_awvalid), .dst_axi_awready(dst_axi_awready),
        .dst_axi_wdata(dst_axi_wdata), .dst_axi_wstrb(dst_axi_wstrb),
        .dst_axi_wvalid(dst_axi_wvalid), .dst_axi_wready(dst_axi_wready),
        .dst_axi_bresp(dst_axi_bresp), .dst_axi_bvalid(dst_axi_bvalid), .dst_axi_bready(dst_axi_bready),
        .dst_axi_araddr(dst_axi_araddr), .dst_axi_arvalid(dst_axi_arvalid), .dst_axi_arready(dst_axi_arready),
        .dst_axi_rdata(dst_axi_rdata), .dst_axi_rresp(dst_axi_rresp),
        .dst_axi_rvalid(dst_axi_rvalid), .dst_axi_rready(dst_axi_rready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        src_axi_awaddr = '0; src_axi_araddr = '0; src_axi_wdata = '0; src_axi_wstrb = '0;
        src_axi_awvalid = '0; src_axi_wvalid = '0; src_axi_bready = '0;
        src_axi_arvalid = '0; src_axi_rready = '0;
        dst_axi_awready = 1'b0; dst_axi_wready = 1'b0; dst_axi_bresp = '0; dst_axi_bvalid = 1'b0;
        dst_axi_arready = 1'b0; dst_axi_rdata = '0; dst_axi_rresp = '0; dst_axi_rvalid = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        chk("rst_awvalid", 64'(dst_axi_awvalid), 64'h0);
        chk("rst_arvalid", 64'(dst_axi_arvalid), 64'h0);
        chk("rst_bvalid",  64'(src_axi_bvalid),  64'h0);
        chk("rst_rvalid",  64'(src_axi_rvalid),  64'h0);
        chk("rst_bready",  64'(dst_axi_bready),  64'h0);
        chk("rst_rready",  64'(dst_axi_rready),  64'h0);
        rst = 1'b0;

        // Single write from src0
        @(negedge clk);
        src_axi_awaddr[0] = 32'h100; src_axi_wdata[0] = 32'hDEADBEEF; src_axi_wstrb[0] = 4'hF;
        src_axi_awvalid = 2'b01; src_axi_wvalid = 2'b01;
        dst_axi_awready = 1'b1; dst_axi_wready = 1'b1;
        #1;
        chk("wr_awvalid", 64'(dst_axi_awvalid), 64'h1);
        chk("wr_wvalid",  64'(dst_axi_wvalid),  64'h1);
        chk("wr_awaddr",  64'(dst_axi_awaddr),  64'h100);
        chk("wr_wdata",   64'(dst_axi_wdata),   64'hDEADBEEF);
        chk("wr_wstrb",   64'(dst_axi_wstrb),   64'hF);
        chk("wr_awready", 64'(src_axi_awready), 64'h1);
        chk("wr_wready",  64'(src_axi_wready),  64'h1);
        @(negedge clk);
        src_axi_awvalid = '0; src_axi_wvalid = '0;
        dst_axi_bvalid = 1'b1; dst_axi_bresp = 2'b00; src_axi_bready = 2'b01;
        #1;
        chk("b_route",   64'(src_axi_bvalid), 64'h1);
        chk("b_resp",    64'(src_axi_bresp),  64'h0);
        chk("b_dready",  64'(dst_axi_bready), 64'h1);
        chk("wr_idle",   64'(dst_axi_awvalid), 64'h0);
        @(negedge clk);
        dst_axi_bvalid = 1'b0;
        #1;
        chk("b_empty", 64'(dst_axi_bready), 64'h0);

        // Round-robin reads, responses interleaved
        @(negedge clk);
        src_axi_araddr[0] = 32'h200; src_axi_araddr[1] = 32'h300;
        src_axi_arvalid = 2'b11; dst_axi_arready = 1'b1; src_axi_rready = 2'b11;
        #1;
        chk("rr0_addr",  64'(dst_axi_araddr),  64'h200);
        chk("rr0_ready", 64'(src_axi_arready), 64'h1);
        @(negedge clk);
        dst_axi_rvalid = 1'b1; dst_axi_rdata = 32'hA5A5A5A5;
        #1;
        chk("rr1_addr",   64'(dst_axi_araddr),  64'h300);
        chk("rr1_ready",  64'(src_axi_arready), 64'h2);
        chk("rr1_rvalid", 64'(src_axi_rvalid),  64'h1);
        chk("rr1_rdata",  64'(src_axi_rdata),   64'h00000000A5A5A5A5);
        chk("rr1_rready", 64'(dst_axi_rready),  64'h1);
        @(negedge clk);
        dst_axi_rdata = 32'h5A5A5A5A;
        #1;
        chk("rr2_addr",   64'(dst_axi_araddr),  64'h200);
        chk("rr2_ready",  64'(src_axi_arready), 64'h1);
        chk("rr2_rvalid", 64'(src_axi_rvalid),  64'h2);
        chk("rr2_rdata",  64'(src_axi_rdata),   64'h5A5A5A5A00000000);
        @(negedge clk);
        src_axi_arvalid = '0; dst_axi_rdata = 32'h11111111;
        #1;
        chk("rr3_rvalid",  64'(src_axi_rvalid),  64'h1);
        chk("rr3_arvalid", 64'(dst_axi_arvalid), 64'h0);
        @(negedge clk);
        dst_axi_rvalid = 1'b0;
        #1;
        chk("rr_empty", 64'(dst_axi_rready), 64'h0);

        // Locked hold: src1 granted (pointer at 0), dst stalls 3 cycles
        @(negedge clk);
        src_axi_arvalid = 2'b11; dst_axi_arready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("lk_addr",  64'(dst_axi_araddr),  64'h300);
            chk("lk_ready", 64'(src_axi_arready), 64'h0);
            @(negedge clk);
        end
        dst_axi_arready = 1'b1;
        #1;
        chk("lk_addr4",  64'(dst_axi_araddr),  64'h300);
        chk("lk_ready4", 64'(src_axi_arready), 64'h2);
        @(negedge clk);
        src_axi_arvalid = 2'b01;
        #1;
        chk("lk_next_addr",  64'(dst_axi_araddr),  64'h200);
        chk("lk_next_ready", 64'(src_axi_arready), 64'h1);

        // FIFO full: two reads outstanding, third blocked until a response pops
        @(negedge clk);
        src_axi_arvalid = 2'b10; dst_axi_rvalid = 1'b1; dst_axi_rdata = 32'hCAFEF00D;
        #1;
        chk("full_arvalid", 64'(dst_axi_arvalid), 64'h0);
        chk("full_arready", 64'(src_axi_arready), 64'h0);
        chk("full_rvalid",  64'(src_axi_rvalid),  64'h2);
        @(negedge clk);
        dst_axi_rvalid = 1'b0;
        #1;
        chk("unfull_arvalid", 64'(dst_axi_arvalid), 64'h1);
        chk("unfull_addr",    64'(dst_axi_araddr),  64'h300);
        chk("unfull_arready", 64'(src_axi_arready), 64'h2);
        @(negedge clk);
        src_axi_arvalid = '0; dst_axi_rvalid = 1'b1;
        #1;
        chk("drain0", 64'(src_axi_rvalid), 64'h1);
        @(negedge clk); #1;
        chk("drain1", 64'(src_axi_rvalid), 64'h2);
        @(negedge clk);
        dst_axi_rvalid = 1'b0;
        #1;
        chk("drain_empty", 64'(dst_axi_rready), 64'h0);

        // Split write valids: no grant until both AW and W valid
        @(negedge clk);
        src_axi_awaddr[0] = 32'h400; src_axi_awvalid = 2'b01; src_axi_wvalid = 2'b00;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("split_awvalid", 64'(dst_axi_awvalid), 64'h0);
            chk("split_wvalid",  64'(dst_axi_wvalid),  64'h0);
            chk("split_awready", 64'(src_axi_awready), 64'h0);
            @(negedge clk);
        end
        src_axi_wvalid = 2'b01;
        #1;
        chk("split_go",    64'(dst_axi_awvalid), 64'h1);
        chk("split_addr",  64'(dst_axi_awaddr),  64'h400);
        chk("split_ready", 64'(src_axi_awready), 64'h1);

        // Async reset with one write outstanding
        @(negedge clk);
        src_axi_awvalid = '0; src_axi_wvalid = '0;
        dst_axi_bvalid = 1'b1; dst_axi_bresp = 2'b10; src_axi_bready = 2'b00;
        #1;
        chk("pre_bvalid", 64'(src_axi_bvalid), 64'h1);
        chk("pre_bresp",  64'(src_axi_bresp),  64'h2);
        chk("pre_bready", 64'(dst_axi_bready), 64'h0);
        src_axi_awaddr[0] = 32'h600; src_axi_awaddr[1] = 32'h500;
        src_axi_awvalid = 2'b11; src_axi_wvalid = 2'b11; src_axi_bready = 2'b01;
        #1;
        chk("pre_rr_addr", 64'(dst_axi_awaddr), 64'h500);
        rst = 1'b1;
        #1;
        chk("arst_bvalid",  64'(src_axi_bvalid),  64'h0);
        chk("arst_bresp",   64'(src_axi_bresp),   64'h0);
        chk("arst_bready",  64'(dst_axi_bready),  64'h0);
        chk("arst_awvalid", 64'(dst_axi_awvalid), 64'h0);
        chk("arst_awready", 64'(src_axi_awready), 64'h0);
        @(negedge clk);
        rst = 1'b0; dst_axi_bvalid = 1'b0;
        #1;
        chk("post_addr",  64'(dst_axi_awaddr),  64'h600);
        chk("post_ready", 64'(src_axi_awready), 64'h1);
        @(negedge clk);
        src_axi_awvalid = '0; src_axi_wvalid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
